// File: rtl/uart_pkg.sv
// Shared UART types: RX FSM states, data-width encodings, oversample rate.
// Helpers for data-bit count and 2-of-3 majority voting.
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  localparam logic [1:0] BITS_5 = 2'b00;
  localparam logic [1:0] BITS_6 = 2'b01;
  localparam logic [1:0] BITS_7 = 2'b10;
  localparam logic [1:0] BITS_8 = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

  function automatic logic [3:0] data_bits(
    input logic [1:0] b
  );
    logic [3:0] n;
    n = 4'd8;
    unique case (b)
      BITS_5: n = 4'd5;
      BITS_6: n = 4'd6;
      BITS_7: n = 4'd7;
      BITS_8: n = 4'd8;
      default: n = 4'd8;
    endcase
    return n;
  endfunction

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: counts 0..div-1, tick at the top count.
// Ports: CLK, RSTN (sync, low), clr (restart count), div, tick.
module uart_baud_tick
  import uart_pkg::*;
(
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        clr,
  input  logic [15:0] div,
  output logic        tick
);

  logic [15:0] cnt;
  logic [15:0] top;

  assign top = (div <= 16'd1) ? 16'd0 : div - 16'd1;

  // >= so a divisor shrunk below the current count cannot stall.
  assign tick = (cnt >= top);

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/uart_rx_oversample.sv
// UART receiver: 16x oversampling, 3-sample vote, parity/frame/break.
// Ports: CLK, RSTN, rx_i, cfg_*, data/flags/valid_o, ready_i, overrun_o, busy_o.
module uart_rx_oversample
  import uart_pkg::*;
(
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        rx_i,
  input  logic [15:0] cfg_div_i,
  input  logic [1:0]  cfg_bits_i,
  input  logic        cfg_parity_en_i,
  input  logic        cfg_parity_odd_i,
  output logic [7:0]  data_o,
  output logic        parity_err_o,
  output logic        frame_err_o,
  output logic        break_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        overrun_o,
  output logic        busy_o
);

  localparam logic [3:0] MID  = 4'(OVERSAMPLE / 2);
  localparam logic [3:0] S_A  = MID - 4'd1;
  localparam logic [3:0] S_B  = MID;
  localparam logic [3:0] S_C  = MID + 4'd1;
  localparam logic [3:0] LAST = 4'(OVERSAMPLE - 1);

  logic       sync1;
  logic       rxs;
  logic       tick;
  logic       start_det;

  rx_state_e  state;
  logic [3:0] scnt;
  logic [3:0] dcnt;
  logic       smp_a;
  logic       smp_b;
  logic [7:0] shreg;
  logic       par_q;
  logic [1:0] bits_q;
  logic       pen_q;
  logic       podd_q;

  logic       vote;
  logic       done;
  logic       c_pe;
  logic       c_fe;
  logic       c_br;

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rx_i;
      rxs   <= sync1;
    end
  end

  assign start_det = tick && (state == ST_IDLE) && !rxs;

  uart_baud_tick u_tick (
    .CLK  (CLK),
    .RSTN (RSTN),
    .clr  (start_det),
    .div  (cfg_div_i),
    .tick (tick)
  );

  // Third sample is the live one; the vote resolves at count S_C.
  assign vote = maj3(smp_a, smp_b, rxs);
  assign done = tick && (state == ST_STOP) && (scnt == S_C);

  assign c_pe = pen_q & (^shreg ^ par_q ^ podd_q);
  assign c_fe = !vote;
  assign c_br = !vote && (shreg == 8'd0) && !(pen_q && par_q);

  assign busy_o = (state != ST_IDLE);

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state  <= ST_IDLE;
      scnt   <= '0;
      dcnt   <= '0;
      smp_a  <= 1'b1;
      smp_b  <= 1'b1;
      shreg  <= '0;
      par_q  <= 1'b0;
      bits_q <= BITS_8;
      pen_q  <= 1'b0;
      podd_q <= 1'b0;
    end else if (tick) begin
      if (state != ST_IDLE && state != ST_BREAK) begin
        scnt <= scnt + 4'd1;
        if (scnt == S_A) smp_a <= rxs;
        if (scnt == S_B) smp_b <= rxs;
      end
      unique case (state)
        ST_IDLE: begin
          if (!rxs) begin
            state  <= ST_START;
            scnt   <= 4'd1;
            dcnt   <= '0;
            shreg  <= '0;
            par_q  <= 1'b0;
            bits_q <= cfg_bits_i;
            pen_q  <= cfg_parity_en_i;
            podd_q <= cfg_parity_odd_i;
          end
        end
        ST_START: begin
          if (scnt == S_C && vote) begin
            state <= ST_IDLE;
          end else if (scnt == LAST) begin
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (scnt == S_C) begin
            shreg[dcnt[2:0]] <= vote;
            dcnt <= dcnt + 4'd1;
          end
          if (scnt == LAST && dcnt == data_bits(bits_q)) begin
            state <= pen_q ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY: begin
          if (scnt == S_C) par_q <= vote;
          if (scnt == LAST) state <= ST_STOP;
        end
        ST_STOP: begin
          // Decide mid stop bit so back-to-back starts are not missed.
          if (scnt == S_C) begin
            state <= c_br ? ST_BREAK : ST_IDLE;
          end
        end
        ST_BREAK: begin
          if (rxs) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      data_o       <= '0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      break_o      <= 1'b0;
      valid_o      <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      overrun_o <= 1'b0;
      if (done) begin
        if (!valid_o || ready_i) begin
          data_o       <= shreg;
          parity_err_o <= c_pe;
          frame_err_o  <= c_fe;
          break_o      <= c_br;
          valid_o      <= 1'b1;
        end else begin
          overrun_o <= 1'b1;
        end
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Directed bench for uart_rx_oversample.
// Frames driven on negedges; characters logged by a negedge monitor.
module tb_uart_rx_oversample;

  logic        CLK;
  logic        RSTN;
  logic        rx_i;
  logic [15:0] cfg_div_i;
  logic [1:0]  cfg_bits_i;
  logic        cfg_parity_en_i;
  logic        cfg_parity_odd_i;
  logic [7:0]  data_o;
  logic        parity_err_o;
  logic        frame_err_o;
  logic        break_o;
  logic        valid_o;
  logic        ready_i;
  logic        overrun_o;
  logic        busy_o;

  int n_tot  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int n_ovr  = 0;
  int n_rise = 0;
  logic v_prev = 1'b0;
  logic [11:0] capq[$];

  uart_rx_oversample dut (
    .CLK              (CLK),
    .RSTN             (RSTN),
    .rx_i             (rx_i),
    .cfg_div_i        (cfg_div_i),
    .cfg_bits_i       (cfg_bits_i),
    .cfg_parity_en_i  (cfg_parity_en_i),
    .cfg_parity_odd_i (cfg_parity_odd_i),
    .data_o           (data_o),
    .parity_err_o     (parity_err_o),
    .frame_err_o      (frame_err_o),
    .break_o          (break_o),
    .valid_o          (valid_o),
    .ready_i          (ready_i),
    .overrun_o        (overrun_o),
    .busy_o           (busy_o)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Entry: {present, break, frame, parity, data}
  always @(negedge CLK) begin
    #3;
    if (valid_o && ready_i)
      capq.push_back({1'b1, break_o, frame_err_o, parity_err_o, data_o});
    if (overrun_o) n_ovr++;
    if (valid_o && !v_prev) n_rise++;
    v_prev = valid_o;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_char(input string tag, input logic [11:0] exp);
    logic [11:0] got;
    got = (capq.size() > 0) ? capq.pop_front() : 12'h000;
    chk(tag, 32'(got), 32'(exp));
  endtask

  task automatic send(input logic [7:0] d, input int nb, input bit pen,
                      input bit podd, input bit pbit, input bit sb,
                      input int div, input bit noise, input int rdy_at);
    logic [11:0] fr;
    int nfb;
    int per;
    cfg_div_i        = 16'(div);
    cfg_bits_i       = 2'(nb - 5);
    cfg_parity_en_i  = pen;
    cfg_parity_odd_i = podd;
    per = (div <= 1) ? 1 : div;
    fr = '1;
    fr[0] = 1'b0;
    for (int i = 0; i < nb; i++) fr[1 + i] = d[i];
    nfb = 1 + nb;
    if (pen) begin
      fr[nfb] = pbit;
      nfb++;
    end
    fr[nfb] = sb;
    nfb++;
    for (int c = 0; c < nfb * 16 * per; c++) begin
      @(negedge CLK);
      rx_i = fr[c / (16 * per)] ^ (noise && ((c % (16 * per)) / per) == 8);
      if (c == rdy_at) ready_i = 1'b1;
    end
    @(negedge CLK);
    rx_i = 1'b1;
    repeat (24) @(negedge CLK);
  endtask

  initial begin : stim
    logic [9:0] fr1;
    int r0;
    RSTN = 1'b0;
    rx_i = 1'b1;
    ready_i = 1'b1;
    cfg_div_i = 16'd1;
    cfg_bits_i = 2'b11;
    cfg_parity_en_i = 1'b0;
    cfg_parity_odd_i = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_data", 32'(data_o), 32'h00);
    chk("rst_valid", 32'(valid_o), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_ovr", 32'(overrun_o), 32'h0);
    chk("rst_flags", 32'({parity_err_o, frame_err_o, break_o}), 32'h0);
    @(negedge CLK);
    RSTN = 1'b1;
    repeat (5) @(negedge CLK);

    // 8N1 0xA5, latency to valid
    fr1 = {1'b1, 8'hA5, 1'b0};
    for (int c = 0; c < 160; c++) begin
      @(negedge CLK);
      rx_i = fr1[c / 16];
      @(posedge CLK);
      #1;
      if (c == 154) begin
        chk("lat_v154", 32'(valid_o), 32'h0);
        chk("lat_busy154", 32'(busy_o), 32'h1);
      end
      if (c == 155) begin
        chk("lat_v155", 32'(valid_o), 32'h1);
        chk("lat_data", 32'(data_o), 32'hA5);
        chk("lat_flags", 32'({parity_err_o, frame_err_o, break_o}), 32'h0);
        chk("lat_busy155", 32'(busy_o), 32'h0);
      end
    end
    @(negedge CLK);
    rx_i = 1'b1;
    repeat (24) @(negedge CLK);
    chk_char("a5_char", 12'h8A5);

    // 7E1 bad parity, good parity; 8O1; 5N1
    send(8'h41, 7, 1, 0, 1, 1, 1, 0, -1);
    chk_char("7e1_bad", 12'h941);
    send(8'h43, 7, 1, 0, 1, 1, 1, 0, -1);
    chk_char("7e1_good", 12'h843);
    send(8'h07, 8, 1, 1, 0, 1, 1, 0, -1);
    chk_char("8o1_good", 12'h807);
    send(8'h15, 5, 0, 0, 0, 1, 1, 0, -1);
    chk_char("5n1", 12'h815);

    // Stop bit low, data nonzero: frame error only
    send(8'h55, 8, 0, 0, 0, 0, 1, 0, -1);
    chk_char("frame_err", 12'hA55);

    // Glitch: 4 ticks low
    r0 = n_rise;
    @(negedge CLK);
    rx_i = 1'b0;
    repeat (4) @(negedge CLK);
    rx_i = 1'b1;
    @(posedge CLK);
    #1;
    chk("glitch_busy", 32'(busy_o), 32'h1);
    repeat (20) @(posedge CLK);
    #1;
    chk("glitch_idle", 32'(busy_o), 32'h0);
    chk("glitch_nov", 32'(n_rise - r0), 32'h0);

    // Break: two frame times low
    r0 = n_rise;
    @(negedge CLK);
    rx_i = 1'b0;
    repeat (320) @(negedge CLK);
    chk_char("break_char", 12'hE00);
    chk("break_busy", 32'(busy_o), 32'h1);
    chk("break_once", 32'(n_rise - r0), 32'h1);
    rx_i = 1'b1;
    repeat (20) @(negedge CLK);
    chk("break_idle", 32'(busy_o), 32'h0);
    send(8'h3C, 8, 0, 0, 0, 1, 1, 0, -1);
    chk_char("after_break", 12'h83C);

    // Overrun
    ready_i = 1'b0;
    r0 = n_ovr;
    send(8'h11, 8, 0, 0, 0, 1, 1, 0, -1);
    chk("ovr_hold1", 32'({valid_o, data_o}), 32'h111);
    send(8'h22, 8, 0, 0, 0, 1, 1, 0, -1);
    chk("ovr_keep", 32'({valid_o, data_o}), 32'h111);
    chk("ovr_pulse", 32'(n_ovr - r0), 32'h1);
    send(8'h33, 8, 0, 0, 0, 1, 1, 0, 155);
    chk_char("ovr_acc11", 12'h811);
    chk_char("ovr_load33", 12'h833);
    chk("ovr_noextra", 32'(n_ovr - r0), 32'h1);

    // Divisor 0 vs 1 vs 3, and noise
    send(8'h5A, 8, 0, 0, 0, 1, 0, 0, -1);
    chk_char("div0", 12'h85A);
    send(8'h5A, 8, 0, 0, 0, 1, 1, 0, -1);
    chk_char("div1", 12'h85A);
    send(8'hC3, 8, 0, 0, 0, 1, 3, 0, -1);
    chk_char("div3", 12'h8C3);
    send(8'h96, 8, 0, 0, 0, 1, 1, 1, -1);
    chk_char("noise", 12'h896);

    // Reset mid-DATA with a held character
    ready_i = 1'b0;
    send(8'h77, 8, 0, 0, 0, 1, 1, 0, -1);
    chk("held77", 32'({valid_o, data_o}), 32'h177);
    @(negedge CLK);
    rx_i = 1'b0;
    repeat (40) @(negedge CLK);
    chk("mid_busy", 32'(busy_o), 32'h1);
    RSTN = 1'b0;
    @(posedge CLK);
    #1;
    chk("mrst_out",
        32'({valid_o, overrun_o, busy_o, parity_err_o, frame_err_o,
             break_o, data_o}), 32'h0);
    @(negedge CLK);
    rx_i = 1'b1;
    repeat (3) @(negedge CLK);
    RSTN = 1'b1;
    ready_i = 1'b1;
    repeat (5) @(negedge CLK);
    send(8'hE1, 8, 0, 0, 0, 1, 1, 0, -1);
    chk_char("post_rst", 12'h8E1);
    chk("q_empty", 32'(capq.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
